mvb_fifox_serializer: RTL and testbench

Feeds a single-item FIFOX write port from a multi-item MVB stream. Each accepted MVB word is held in a local register, and its valid items are written into the FIFOX one per cycle, in ascending item index. While it drains, the block back-pressures the MVB source. It sits directly upstream of the FIFOX write side and adds no buffering beyond one MVB word.

---
 rtl/mvb_fifox_serializer_pkg.sv | 27 ++
 rtl/mvb_fifox_serializer_if.sv | 24 ++
 rtl/mvb_fifox_serializer_first_one.sv | 18 +
 rtl/mvb_fifox_serializer.sv | 82 ++++++++
 tb/tb_mvb_fifox_serializer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mvb_fifox_serializer_pkg.sv
// Shared constants, state type and mask helpers for the MVB-to-FIFOX serializer.
package mvb_fifox_pkg;

  localparam int unsigned ITEM_CNT_W = 32;
  localparam int unsigned MAX_ITEMS  = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Lowest set index of mask; 0 when mask is empty.
  function automatic int unsigned first_one(input logic [MAX_ITEMS-1:0] mask);
    int unsigned r;
    r = 0;
    for (int i = MAX_ITEMS - 1; i >= 0; i--) begin
      if (mask[i]) r = unsigned'(i);
    end
    return r;
  endfunction

  // True when at most one bit of mask is set.
  function automatic logic one_hot_or_zero(input logic [MAX_ITEMS-1:0] mask);
    return (mask & (mask - MAX_ITEMS'(1))) == '0;
  endfunction

endpackage

// File: rtl/mvb_fifox_serializer_if.sv
// MVB receive bus and single-item FIFOX write bus.
interface mvb_if #(
  parameter int unsigned ITEMS      = 4,
  parameter int unsigned ITEM_WIDTH = 32
);
  logic [ITEMS*ITEM_WIDTH-1:0] data;
  logic [ITEMS-1:0]            vld;
  logic                        src_rdy;
  logic                        dst_rdy;

  modport master (output data, vld, src_rdy, input dst_rdy);
  modport slave  (input data, vld, src_rdy, output dst_rdy);
endinterface

interface fifox_wr_if #(
  parameter int unsigned ITEM_WIDTH = 32
);
  logic [ITEM_WIDTH-1:0] data;
  logic                  wr;
  logic                  full;

  modport master (output data, wr, input full);
  modport slave  (input data, wr, output full);
endinterface

// File: rtl/mvb_fifox_serializer_first_one.sv
// Priority encoder: index of the lowest set bit plus an any-set flag.
module mvb_first_one
  import mvb_fifox_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  always_comb begin
    idx_c = IDX_W'(first_one(MAX_ITEMS'(mask)));
    any_c = |mask;
  end

endmodule

// File: rtl/mvb_fifox_serializer.sv
// Holds one MVB word and writes its valid items into a FIFOX one per cycle,
// lowest index first, back-pressuring the MVB source while draining.
module mvb_fifox_serializer
  import mvb_fifox_pkg::*;
#(
  parameter int unsigned ITEMS      = 4,
  parameter int unsigned ITEM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mvb_if.slave                  rx,
  fifox_wr_if.master            fx,
  output logic [ITEM_CNT_W-1:0] item_cnt
);

  localparam int unsigned IDX_W = (ITEMS > 1) ? $clog2(ITEMS) : 1;

  logic [ITEMS-1:0][ITEM_WIDTH-1:0] hold_q, hold_d;
  logic [ITEMS-1:0]                 pend_q, pend_d;
  logic [ITEM_CNT_W-1:0]            cnt_d;
  logic [IDX_W-1:0]                 sel_c;
  logic                             any_c;
  logic                             wr_c;
  logic                             rdy_c;
  state_t                           state_c;

  mvb_first_one #(.WIDTH(ITEMS)) u_sel (
    .mask  (pend_q),
    .idx_c (sel_c),
    .any_c (any_c)
  );

  // The pending mask is the state register; the state is just its emptiness.
  assign state_c = any_c ? ST_DRAIN : ST_IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q   <= '0;
      pend_q   <= '0;
      item_cnt <= '0;
    end else begin
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      item_cnt <= cnt_d;
    end
  end

  // Write the selected item, clear its bit, and load a new word when ready;
  // a load in the same cycle as the last write overrides the cleared mask.
  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q;
    cnt_d  = item_cnt;
    wr_c   = 1'b0;
    rdy_c  = 1'b0;

    case (state_c)
      ST_IDLE: begin
        rdy_c = reset;
      end
      ST_DRAIN: begin
        wr_c  = ~fx.full;
        rdy_c = reset & one_hot_or_zero(MAX_ITEMS'(pend_q)) & ~fx.full;
      end
    endcase

    if (wr_c) begin
      pend_d[sel_c] = 1'b0;
      cnt_d         = item_cnt + ITEM_CNT_W'(1);
    end

    if (rdy_c && rx.src_rdy) begin
      hold_d = rx.data;
      pend_d = rx.vld;
    end
  end

  assign fx.wr      = wr_c;
  assign fx.data    = hold_q[sel_c];
  assign rx.dst_rdy = rdy_c;

endmodule

// File: tb/tb_mvb_fifox_serializer.sv
// Directed and random checks of mvb_fifox_serializer with ITEMS=4, ITEM_WIDTH=32.
module tb_mvb_fifox_serializer;

  localparam int unsigned N_WORDS   = 10000;
  localparam int          CYC_LIMIT = 80000;

  logic        clk;
  logic        reset;
  logic [31:0] item_cnt;

  int          n_checks;
  int          n_fail;
  logic [31:0] q[$];
  int          words;
  int          cyc;
  logic [31:0] total;
  logic        exp_wr;
  logic        exp_rdy;

  mvb_if #(.ITEMS(4), .ITEM_WIDTH(32)) rx ();
  fifox_wr_if #(.ITEM_WIDTH(32))       fx ();

  mvb_fifox_serializer #(.ITEMS(4), .ITEM_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .fx       (fx),
    .item_cnt (item_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    rx.src_rdy = 1'b1;
    rx.vld     = 4'h0;
    rx.data    = '0;
    fx.full    = 1'b0;

    // Reset held with a word offered
    for (int i = 0; i < 5; i++) begin
      tick(); settle();
      chk("rst_rdy", rx.dst_rdy, 0);
      chk("rst_wr", fx.wr, 0);
      chk("rst_cnt", item_cnt, 0);
    end
    chk("rst_data", fx.data, 0);
    tick();
    reset      = 1'b1;
    rx.src_rdy = 1'b0;
    settle();
    chk("rel_rdy", rx.dst_rdy, 1);

    // Full word
    rx.data    = {32'h13, 32'h12, 32'h11, 32'h10};
    rx.vld     = 4'b1111;
    rx.src_rdy = 1'b1;
    settle();
    chk("full_acc_rdy", rx.dst_rdy, 1);
    tick();
    rx.src_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("full_wr", fx.wr, 1);
      chk("full_data", fx.data, 64'(32'h10 + i));
      chk("full_cnt_run", item_cnt, 64'(i));
      tick();
    end
    settle();
    chk("full_wr_end", fx.wr, 0);
    chk("full_cnt", item_cnt, 4);

    // Sparse, empty, single words back to back
    rx.data    = {32'h23, 32'h22, 32'h21, 32'h20};
    rx.vld     = 4'b1010;
    rx.src_rdy = 1'b1;
    settle();
    chk("sp_a_rdy", rx.dst_rdy, 1);
    tick();
    rx.data = {32'h33, 32'h32, 32'h31, 32'h30};
    rx.vld  = 4'b0000;
    settle();
    chk("sp_a1_wr", fx.wr, 1);
    chk("sp_a1_data", fx.data, 32'h21);
    chk("sp_a1_rdy", rx.dst_rdy, 0);
    tick();
    settle();
    chk("sp_a3_wr", fx.wr, 1);
    chk("sp_a3_data", fx.data, 32'h23);
    chk("sp_a3_rdy", rx.dst_rdy, 1);
    tick();
    rx.data = {32'h43, 32'h42, 32'h41, 32'h40};
    rx.vld  = 4'b0001;
    settle();
    chk("sp_gap_wr", fx.wr, 0);
    chk("sp_gap_rdy", rx.dst_rdy, 1);
    tick();
    rx.src_rdy = 1'b0;
    settle();
    chk("sp_c0_wr", fx.wr, 1);
    chk("sp_c0_data", fx.data, 32'h40);
    chk("sp_c0_cnt", item_cnt, 6);
    tick();
    settle();
    chk("sp_end_wr", fx.wr, 0);
    chk("sp_cnt", item_cnt, 7);

    // FIFOX full stall on the second item
    rx.data    = {32'h53, 32'h52, 32'h51, 32'h50};
    rx.vld     = 4'b1111;
    rx.src_rdy = 1'b1;
    settle();
    tick();
    rx.src_rdy = 1'b0;
    settle();
    chk("bp_d0_data", fx.data, 32'h50);
    chk("bp_d0_wr", fx.wr, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      fx.full = 1'b1;
      settle();
      chk("bp_stall_wr", fx.wr, 0);
      chk("bp_stall_data", fx.data, 32'h51);
      chk("bp_stall_rdy", rx.dst_rdy, 0);
      tick();
    end
    fx.full = 1'b0;
    for (int i = 1; i < 4; i++) begin
      settle();
      chk("bp_wr", fx.wr, 1);
      chk("bp_data", fx.data, 64'(32'h50 + i));
      chk("bp_rdy", rx.dst_rdy, (i == 3) ? 64'd1 : 64'd0);
      tick();
    end
    settle();
    chk("bp_end_wr", fx.wr, 0);
    chk("bp_cnt", item_cnt, 11);

    // Reset after two of four items
    rx.data    = {32'h63, 32'h62, 32'h61, 32'h60};
    rx.vld     = 4'b1111;
    rx.src_rdy = 1'b1;
    settle();
    tick();
    rx.src_rdy = 1'b0;
    settle();
    chk("rm_d0", fx.data, 32'h60);
    tick();
    settle();
    chk("rm_d1", fx.data, 32'h61);
    tick();
    settle();
    chk("rm_cnt_pre", item_cnt, 13);
    reset = 1'b0;
    #1;
    chk("rm_wr", fx.wr, 0);
    chk("rm_cnt", item_cnt, 0);
    chk("rm_rdy", rx.dst_rdy, 0);
    chk("rm_data", fx.data, 0);
    tick(); settle();
    chk("rm_wr_hold", fx.wr, 0);
    tick();
    reset      = 1'b1;
    rx.data    = {32'h73, 32'h72, 32'h71, 32'h70};
    rx.vld     = 4'b0101;
    rx.src_rdy = 1'b1;
    settle();
    chk("rm_next_rdy", rx.dst_rdy, 1);
    tick();
    rx.src_rdy = 1'b0;
    settle();
    chk("rm_g0_wr", fx.wr, 1);
    chk("rm_g0_data", fx.data, 32'h70);
    tick(); settle();
    chk("rm_g2_wr", fx.wr, 1);
    chk("rm_g2_data", fx.data, 32'h72);
    tick(); settle();
    chk("rm_g_end_wr", fx.wr, 0);
    chk("rm_g_cnt", item_cnt, 2);

    // Random stress against a queue of expected items
    words = 0;
    cyc   = 0;
    total = 32'd2;
    while ((words < int'(N_WORDS) || q.size() != 0) && cyc < CYC_LIMIT) begin
      tick();
      rx.src_rdy = (words < int'(N_WORDS)) && ($urandom_range(7) != 0);
      rx.vld     = 4'($urandom_range(15));
      rx.data    = {$urandom(), $urandom(), $urandom(), $urandom()};
      fx.full    = ($urandom_range(7) == 0);
      settle();
      exp_wr  = (q.size() != 0) && !fx.full;
      exp_rdy = (q.size() == 0) || (q.size() == 1 && !fx.full);
      chk("st_wr", fx.wr, exp_wr);
      chk("st_rdy", rx.dst_rdy, exp_rdy);
      if (exp_wr) begin
        chk("st_data", fx.data, q[0]);
        void'(q.pop_front());
        total = total + 32'd1;
      end
      if (exp_rdy && rx.src_rdy) begin
        words++;
        for (int i = 0; i < 4; i++) begin
          if (rx.vld[i]) q.push_back(rx.data[i*32 +: 32]);
        end
      end
      cyc++;
    end
    chk("st_timeout", (cyc < CYC_LIMIT) ? 64'd1 : 64'd0, 1);
    tick();
    rx.src_rdy = 1'b0;
    fx.full    = 1'b0;
    settle();
    chk("st_cnt", item_cnt, total);
    chk("st_idle_wr", fx.wr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
